// File: rtl/rtlinf_pkg.sv
// Shared definitions for the RTLinf run sequencer.
// Holds the run-state encoding, the default distribute-mode width and the
// helper that sizes the total-write count (iterations x reads per iteration).
package rtlinf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } run_state_e;

  localparam int CONF_MODE_WIDTH_DEF = 2;

  // Width of the unsigned product num_iters * num_reads_per_iter.
  function automatic int total_width(input int iters_w, input int reads_w);
    return iters_w + reads_w;
  endfunction

endpackage

// File: rtl/rtlinf_write_counter.sv
// Single-output write-pulse counter for the run sequencer.
// Counts WRITE valid pulses up to the job total and flags a pulse that
// arrives once the output has already reached its total.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_clr              clear the count (new job accepted)
//   i_en               counting enabled (RUN state)
//   i_valid            WRITE valid_out for this output
//   i_total            job total for this output
//   o_full_next        count will equal total after this cycle
//   o_overrun_hit      pulse seen while the count already equals total
module rtlinf_write_counter
  import rtlinf_pkg::*;
#(
  parameter int W = total_width(16, 16)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_total,
  output logic         o_full_next,
  output logic         o_overrun_hit
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_next;

  // Next count: saturate at the job total, report overrun pulses.
  always_comb begin
    w_cnt_next    = r_cnt;
    o_overrun_hit = 1'b0;
    if (i_en && i_valid) begin
      if (r_cnt < i_total) begin
        w_cnt_next = r_cnt + {{(W-1){1'b0}}, 1'b1};
      end else begin
        o_overrun_hit = 1'b1;
      end
    end else begin
      w_cnt_next = r_cnt;
    end
    o_full_next = (w_cnt_next == i_total);
  end

  // Count register, cleared on reset and when a new job is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/rtlinf_run_ctrl.sv
// Top-level run sequencer for the RTLinf accelerator.
// Latches a job descriptor on start, broadcasts it with a one-cycle configure
// strobe, then counts WRITE valid pulses per output until every output has
// written num_iters*num_reads_per_iter words. A watchdog catches a stalled
// datapath, abort cancels a job, and extra pulses raise a sticky overrun flag.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_start, i_abort            job request (IDLE only) / cancel
//   i_num_iters .. i_conf_mode  job descriptor inputs
//   i_wr_valid_in               WRITE valid_out, one bit per output
//   o_configure                 one-cycle config strobe
//   o_cfg_*                     latched job descriptor
//   o_busy, o_done              not-idle level / completion pulse
//   o_timeout_err, o_overrun_err sticky error flags
//   o_cycle_count               RUN cycles of the last or current job
module rtlinf_run_ctrl
  import rtlinf_pkg::*;
#(
  parameter int NUM_INPUTS             = 1,
  parameter int NUM_OUTPUTS            = 1,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16,
  parameter int CONF_MODE_WIDTH        = CONF_MODE_WIDTH_DEF,
  parameter int WATCHDOG_CYCLES        = 65535
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  input  logic                                   i_abort,
  input  logic [LOG_MAX_ITERS-1:0]               i_num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]      i_num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS*NUM_INPUTS-1:0]  i_read_address,
  input  logic [LOG_MAX_ADDRESS-1:0]             i_weights_address,
  input  logic [LOG_MAX_ADDRESS*NUM_OUTPUTS-1:0] i_write_address,
  input  logic [CONF_MODE_WIDTH-1:0]             i_conf_mode,
  input  logic [NUM_OUTPUTS-1:0]                 i_wr_valid_in,
  output logic                                   o_configure,
  output logic [LOG_MAX_ITERS-1:0]               o_cfg_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0]      o_cfg_num_reads_per_iter,
  output logic [LOG_MAX_ADDRESS*NUM_INPUTS-1:0]  o_cfg_read_address,
  output logic [LOG_MAX_ADDRESS-1:0]             o_cfg_weights_address,
  output logic [LOG_MAX_ADDRESS*NUM_OUTPUTS-1:0] o_cfg_write_address,
  output logic [CONF_MODE_WIDTH-1:0]             o_cfg_conf_mode,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_timeout_err,
  output logic                                   o_overrun_err,
  output logic [31:0]                            o_cycle_count
);

  localparam int          TW       = total_width(LOG_MAX_ITERS, LOG_MAX_READS_PER_ITER);
  localparam logic [31:0] WD_LIMIT = 32'(WATCHDOG_CYCLES);

  run_state_e       r_state;
  run_state_e       w_next_state;
  logic [TW-1:0]    r_total;
  logic [31:0]      r_wd;
  logic [31:0]      w_wd_next;
  logic             w_wd_expire;
  logic             w_start_accept;
  logic             w_run;
  logic             w_all_full;
  logic [NUM_OUTPUTS-1:0] w_full_next;
  logic [NUM_OUTPUTS-1:0] w_overrun_hit;
  logic             w_configure_next;
  logic             w_busy_next;
  logic             w_done_next;

  assign w_start_accept = (r_state == ST_IDLE) && i_start;
  assign w_run          = (r_state == ST_RUN);
  assign w_all_full     = &w_full_next;

  // Idle-cycle watchdog: any write pulse restarts the count.
  assign w_wd_next   = (|i_wr_valid_in) ? 32'd0 : (r_wd + 32'd1);
  assign w_wd_expire = (WD_LIMIT != 32'd0) && (w_wd_next == WD_LIMIT);

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_wr_cnt
    rtlinf_write_counter #(.W(TW)) u_wr_cnt (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clr         (w_start_accept),
      .i_en          (w_run),
      .i_valid       (i_wr_valid_in[g]),
      .i_total       (r_total),
      .o_full_next   (w_full_next[g]),
      .o_overrun_hit (w_overrun_hit[g])
    );
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; abort beats completion, completion beats timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_CONFIG;
        else         w_next_state = ST_IDLE;
      end
      ST_CONFIG: begin
        if (i_abort)                      w_next_state = ST_IDLE;
        else if (r_total == {TW{1'b0}})   w_next_state = ST_DONE;
        else                              w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (i_abort)          w_next_state = ST_IDLE;
        else if (w_all_full)  w_next_state = ST_DONE;
        else if (w_wd_expire) w_next_state = ST_ERROR;
        else                  w_next_state = ST_RUN;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      ST_ERROR: begin
        if (i_abort) w_next_state = ST_IDLE;
        else         w_next_state = ST_ERROR;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the strobes leave a flop.
  always_comb begin
    w_configure_next = 1'b0;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    case (w_next_state)
      ST_IDLE:   w_busy_next = 1'b0;
      ST_CONFIG: begin w_configure_next = 1'b1; w_busy_next = 1'b1; end
      ST_RUN:    w_busy_next = 1'b1;
      ST_DONE:   begin w_done_next = 1'b1; w_busy_next = 1'b1; end
      ST_ERROR:  w_busy_next = 1'b1;
      default:   w_busy_next = 1'b0;
    endcase
  end

  // Registered FSM strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_configure <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_configure <= w_configure_next;
      o_busy      <= w_busy_next;
      o_done      <= w_done_next;
    end
  end

  // Descriptor latch, job total, watchdog, cycle counter and error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cfg_num_iters          <= {LOG_MAX_ITERS{1'b0}};
      o_cfg_num_reads_per_iter <= {LOG_MAX_READS_PER_ITER{1'b0}};
      o_cfg_read_address       <= {(LOG_MAX_ADDRESS*NUM_INPUTS){1'b0}};
      o_cfg_weights_address    <= {LOG_MAX_ADDRESS{1'b0}};
      o_cfg_write_address      <= {(LOG_MAX_ADDRESS*NUM_OUTPUTS){1'b0}};
      o_cfg_conf_mode          <= {CONF_MODE_WIDTH{1'b0}};
      r_total                  <= {TW{1'b0}};
      r_wd                     <= 32'd0;
      o_cycle_count            <= 32'd0;
      o_timeout_err            <= 1'b0;
      o_overrun_err            <= 1'b0;
    end else if (w_start_accept) begin
      o_cfg_num_iters          <= i_num_iters;
      o_cfg_num_reads_per_iter <= i_num_reads_per_iter;
      o_cfg_read_address       <= i_read_address;
      o_cfg_weights_address    <= i_weights_address;
      o_cfg_write_address      <= i_write_address;
      o_cfg_conf_mode          <= i_conf_mode;
      r_total                  <= TW'(i_num_iters) * TW'(i_num_reads_per_iter);
      r_wd                     <= 32'd0;
      o_cycle_count            <= 32'd0;
      o_timeout_err            <= 1'b0;
      o_overrun_err            <= 1'b0;
    end else if (w_run) begin
      r_wd <= w_wd_next;
      if (o_cycle_count != 32'hFFFF_FFFF) o_cycle_count <= o_cycle_count + 32'd1;
      if (|w_overrun_hit) o_overrun_err <= 1'b1;
      // Only a genuine RUN->ERROR transition is a timeout (abort/completion win).
      if (w_next_state == ST_ERROR) o_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtlinf_run_ctrl.sv
module tb_rtlinf_run_ctrl;

  localparam int WD = 10;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_iters;
  logic [15:0] num_reads;
  logic [31:0] read_address;
  logic [15:0] weights_address;
  logic [31:0] write_address;
  logic [1:0]  conf_mode;
  logic [1:0]  wr_valid;

  logic        configure;
  logic [15:0] cfg_num_iters;
  logic [15:0] cfg_num_reads;
  logic [31:0] cfg_read_address;
  logic [15:0] cfg_weights_address;
  logic [31:0] cfg_write_address;
  logic [1:0]  cfg_conf_mode;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        overrun_err;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  rtlinf_run_ctrl #(
    .NUM_INPUTS(2), .NUM_OUTPUTS(2), .LOG_MAX_ITERS(16),
    .LOG_MAX_READS_PER_ITER(16), .LOG_MAX_ADDRESS(16),
    .CONF_MODE_WIDTH(2), .WATCHDOG_CYCLES(WD)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_num_iters(num_iters), .i_num_reads_per_iter(num_reads),
    .i_read_address(read_address), .i_weights_address(weights_address),
    .i_write_address(write_address), .i_conf_mode(conf_mode),
    .i_wr_valid_in(wr_valid),
    .o_configure(configure), .o_cfg_num_iters(cfg_num_iters),
    .o_cfg_num_reads_per_iter(cfg_num_reads),
    .o_cfg_read_address(cfg_read_address),
    .o_cfg_weights_address(cfg_weights_address),
    .o_cfg_write_address(cfg_write_address),
    .o_cfg_conf_mode(cfg_conf_mode),
    .o_busy(busy), .o_done(done), .o_timeout_err(timeout_err),
    .o_overrun_err(overrun_err), .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural job model ----------------
  string       m_phase = "idle";
  bit          m_valid = 1'b0;
  logic [15:0] m_iters = 16'd0, m_reads = 16'd0, m_waddr_w = 16'd0;
  logic [31:0] m_raddr = 32'd0, m_wraddr = 32'd0;
  logic [1:0]  m_mode = 2'd0;
  longint      m_total = 0;
  longint      m_cnt[2];
  longint      m_idle = 0;
  logic [31:0] m_cycles = 32'd0;
  bit          m_tmo = 1'b0, m_ovr = 1'b0;
  bit          m_any, m_all;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (rst) begin
      m_phase = "idle"; m_iters = 16'd0; m_reads = 16'd0; m_raddr = 32'd0;
      m_waddr_w = 16'd0; m_wraddr = 32'd0; m_mode = 2'd0; m_total = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_idle = 0; m_cycles = 32'd0;
      m_tmo = 1'b0; m_ovr = 1'b0;
    end else if (m_phase == "idle") begin
      if (start) begin
        m_iters = num_iters; m_reads = num_reads; m_raddr = read_address;
        m_waddr_w = weights_address; m_wraddr = write_address; m_mode = conf_mode;
        m_total = longint'(num_iters) * longint'(num_reads);
        m_cnt[0] = 0; m_cnt[1] = 0; m_idle = 0; m_cycles = 32'd0;
        m_tmo = 1'b0; m_ovr = 1'b0;
        m_phase = "cfg";
      end
    end else if (m_phase == "cfg") begin
      if (abort) m_phase = "idle";
      else m_phase = (m_total == 0) ? "done" : "run";
    end else if (m_phase == "run") begin
      m_any = 1'b0;
      for (int o = 0; o < 2; o++) begin
        if (wr_valid[o]) begin
          m_any = 1'b1;
          if (m_cnt[o] < m_total) m_cnt[o]++;
          else m_ovr = 1'b1;
        end
      end
      if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
      m_idle = m_any ? 0 : m_idle + 1;
      m_all = (m_cnt[0] == m_total) && (m_cnt[1] == m_total);
      if (abort) m_phase = "idle";
      else if (m_all) m_phase = "done";
      else if (m_idle >= WD) begin m_tmo = 1'b1; m_phase = "err"; end
    end else if (m_phase == "done") begin
      m_phase = "idle";
    end else begin
      if (abort) m_phase = "idle";
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("configure", configure, (m_phase == "cfg"));
      chk("busy", busy, (m_phase != "idle"));
      chk("done", done, (m_phase == "done"));
      chk("timeout_err", timeout_err, m_tmo);
      chk("overrun_err", overrun_err, m_ovr);
      chk("cycle_count", cycle_count, m_cycles);
      chk("cfg_num_iters", cfg_num_iters, m_iters);
      chk("cfg_num_reads", cfg_num_reads, m_reads);
      chk("cfg_read_address", cfg_read_address, m_raddr);
      chk("cfg_weights_address", cfg_weights_address, m_waddr_w);
      chk("cfg_write_address", cfg_write_address, m_wraddr);
      chk("cfg_conf_mode", cfg_conf_mode, m_mode);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_job(input logic [15:0] it, input logic [15:0] rd, input logic [15:0] tag);
    num_iters = it; num_reads = rd;
    read_address = {tag ^ 16'h2222, tag ^ 16'h1111};
    weights_address = tag ^ 16'hABCD;
    write_address = {tag ^ 16'h4444, tag ^ 16'h3333};
    conf_mode = tag[1:0] ^ 2'd2;
  endtask

  logic [1:0] t3_vec [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01,
                              2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 2'b00;
    set_job(16'd0, 16'd0, 16'h0000);
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_cfg_iters", cfg_num_iters, 16'd0);
    rst = 1'b0;
    tick();

    // Job 1: 3x2 = 6 writes on both outputs.
    set_job(16'd3, 16'd2, 16'h0000); start = 1'b1;
    tick();                                   // t=1
    start = 1'b0;
    chk("t1_configure", configure, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_read_addr", cfg_read_address, 32'h0DDD_2EEE ^ 32'h2FFF_3FFF ^ 32'h2222_1111 ^ 32'h0DDD_2EEE ^ 32'h2FFF_3FFF);
    tick();                                   // t=2, RUN
    chk("t1_configure_off", configure, 1'b0);
    for (int i = 0; i < 6; i++) begin wr_valid = 2'b11; tick(); end
    wr_valid = 2'b00;
    chk("t1_done", done, 1'b1);
    chk("t1_cycles", cycle_count, 32'd6);
    tick();
    chk("t1_done_once", done, 1'b0);
    chk("t1_idle", busy, 1'b0);

    // Job 2: zero iterations completes straight from CONFIG.
    set_job(16'd0, 16'd5, 16'h0101); start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_configure", configure, 1'b1);
    tick();
    chk("t2_done", done, 1'b1);
    tick();
    chk("t2_idle", busy, 1'b0);
    chk("t2_cycles", cycle_count, 32'd0);

    // Job 3: total 4, output 0 fast plus an extra pulse, output 1 slow.
    set_job(16'd2, 16'd2, 16'h0202); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      wr_valid = t3_vec[i];
      tick();
      if (i < 11) chk("t3_not_done", done, 1'b0);
    end
    wr_valid = 2'b00;
    chk("t3_done", done, 1'b1);
    chk("t3_overrun", overrun_err, 1'b1);
    chk("t3_cycles", cycle_count, 32'd12);
    tick();

    // Job 4: watchdog expires after 10 silent RUN cycles.
    set_job(16'd5, 16'd1, 16'h0303); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    wr_valid = 2'b11; tick(); tick();
    wr_valid = 2'b00;
    repeat (9) tick();
    chk("t4_no_timeout_yet", timeout_err, 1'b0);
    tick();
    chk("t4_timeout", timeout_err, 1'b1);
    chk("t4_busy", busy, 1'b1);
    chk("t4_cycles", cycle_count, 32'd12);
    repeat (3) tick();
    chk("t4_error_holds", busy, 1'b1);
    chk("t4_no_done", done, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_idle", busy, 1'b0);
    chk("t4_timeout_kept", timeout_err, 1'b1);

    // Job 5: start+abort in IDLE (start wins), start during RUN ignored.
    set_job(16'd1, 16'd3, 16'h0404); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("t5_configure", configure, 1'b1);
    chk("t5_timeout_cleared", timeout_err, 1'b0);
    tick();
    set_job(16'd7, 16'd7, 16'h0505); start = 1'b1;
    wr_valid = 2'b11; tick();
    chk("t5_no_reconfig", configure, 1'b0);
    tick(); start = 1'b0;
    tick(); wr_valid = 2'b00;
    chk("t5_done", done, 1'b1);
    chk("t5_cfg_iters", cfg_num_iters, 16'd1);
    chk("t5_cfg_reads", cfg_num_reads, 16'd3);
    tick();
    wr_valid = 2'b11; tick(); tick(); wr_valid = 2'b00;
    chk("t5_no_idle_overrun", overrun_err, 1'b0);

    // Abort in CONFIG keeps that cycle's configure; abort in RUN gives no done.
    set_job(16'd2, 16'd2, 16'h0606); start = 1'b1;
    tick(); start = 1'b0; abort = 1'b1;
    chk("t6_cfg_abort_configure", configure, 1'b1);
    tick(); abort = 1'b0;
    chk("t6_cfg_abort_idle", busy, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    wr_valid = 2'b01; tick(); wr_valid = 2'b00;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_run_abort_idle", busy, 1'b0);
    tick();
    chk("t6_run_abort_no_done", done, 1'b0);

    // Reset mid-RUN, then a fresh one-write job.
    set_job(16'd4, 16'd1, 16'h0707); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    wr_valid = 2'b11; tick(); wr_valid = 2'b00;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_cycles", cycle_count, 32'd0);
    chk("t7_rst_cfg", cfg_weights_address, 16'd0);
    set_job(16'd1, 16'd1, 16'h0808); start = 1'b1;
    tick(); start = 1'b0;
    chk("t7_configure", configure, 1'b1);
    tick();
    wr_valid = 2'b11; tick(); wr_valid = 2'b00;
    chk("t7_done", done, 1'b1);
    chk("t7_cycles", cycle_count, 32'd1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
